cpu_multi: RTL

CPU_MULTI -- requirements
Module: cpu_multi

---
 rtl/cpu_multi.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_multi.sv
// Multi-cycle LEGv8-subset core: one instruction at a time through
// FETCH/DECODE/EXEC/MEM with request/ack handshakes on both memory ports.
module cpu_multi #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [DATA_W-1:0]       imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_rdata,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [DATA_W-1:0]       dmem_addr,
    output logic [DATA_W-1:0]       dmem_wdata,
    input  logic                    dmem_ack,
    input  logic [DATA_W-1:0]       dmem_rdata,
    output logic [DATA_W-1:0]       pc_out,
    output logic                    halted,
    output logic [31:0][DATA_W-1:0] reg_out
);

    // state    | meaning
    // S_FETCH  | imem request held until ack; IR captured on ack edge
    // S_DECODE | operands A/B read from the register file
    // S_EXEC   | ALU/branch retire, or data address formed for LDUR/STUR
    // S_MEM    | dmem request held until ack; LDUR writes back on ack edge
    // S_HALT   | all-zero instruction seen; frozen until rst
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_pc, r_a, r_b, r_addr;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_regs [0:30];
    logic              r_n, r_z, r_c, r_v;

    logic              w_is_addi, w_is_adds, w_is_subs, w_is_and, w_is_eor, w_is_lsr;
    logic              w_is_ldur, w_is_stur, w_is_b, w_is_cbz, w_is_blt, w_is_halt, w_is_mem;
    logic [4:0]        w_rd, w_rn, w_rm;
    logic [DATA_W-1:0] w_rn_val, w_rm_val, w_rt_val;
    logic [DATA_W-1:0] w_add_b, w_sum, w_res, w_imm12, w_off_b, w_off_c, w_pc_next, w_daddr;
    logic              w_carry, w_ovf, w_wen, w_taken;
    logic [5:0]        w_shamt;

    assign w_rd = r_ir[4:0];
    assign w_rn = r_ir[9:5];
    assign w_rm = r_ir[20:16];

    assign w_is_addi = (r_ir[31:22] == 10'b1001000100);
    assign w_is_adds = (r_ir[31:21] == 11'b10101011000);
    assign w_is_subs = (r_ir[31:21] == 11'b11101011000);
    assign w_is_and  = (r_ir[31:21] == 11'b10001010000);
    assign w_is_eor  = (r_ir[31:21] == 11'b11001010000);
    assign w_is_lsr  = (r_ir[31:21] == 11'b11010011010);
    assign w_is_ldur = (r_ir[31:21] == 11'b11111000010);
    assign w_is_stur = (r_ir[31:21] == 11'b11111000000);
    assign w_is_b    = (r_ir[31:26] == 6'b000101);
    assign w_is_cbz  = (r_ir[31:24] == 8'b10110100);
    assign w_is_blt  = (r_ir[31:24] == 8'b01010100) && (r_ir[4:0] == 5'b01011);
    assign w_is_halt = (r_ir == 32'd0);
    assign w_is_mem  = w_is_ldur || w_is_stur;

    // X31 is the zero register: never stored, always reads 0
    assign w_rn_val = (w_rn == 5'd31) ? '0 : r_regs[w_rn];
    assign w_rm_val = (w_rm == 5'd31) ? '0 : r_regs[w_rm];
    assign w_rt_val = (w_rd == 5'd31) ? '0 : r_regs[w_rd];

    // SUBS computes A + ~B + 1 so carry is the true adder carry-out
    assign w_add_b = w_is_subs ? ~r_b : r_b;
    assign {w_carry, w_sum} = {1'b0, r_a} + {1'b0, w_add_b} + (DATA_W+1)'(w_is_subs);
    assign w_ovf = (r_a[DATA_W-1] == w_add_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);

    assign w_shamt = r_ir[15:10];
    assign w_imm12 = {{(DATA_W-12){1'b0}}, r_ir[21:10]};
    assign w_off_b = {{(DATA_W-26){r_ir[25]}}, r_ir[25:0]} << 2;
    assign w_off_c = {{(DATA_W-19){r_ir[23]}}, r_ir[23:5]} << 2;
    assign w_daddr = r_a + {{(DATA_W-9){r_ir[20]}}, r_ir[20:12]};

    always_comb begin
        w_res = '0;
        w_wen = 1'b0;
        if (w_is_addi) begin
            w_res = r_a + w_imm12;
            w_wen = 1'b1;
        end else if (w_is_adds || w_is_subs) begin
            w_res = w_sum;
            w_wen = 1'b1;
        end else if (w_is_and) begin
            w_res = r_a & r_b;
            w_wen = 1'b1;
        end else if (w_is_eor) begin
            w_res = r_a ^ r_b;
            w_wen = 1'b1;
        end else if (w_is_lsr) begin
            w_res = ({26'd0, w_shamt} >= DATA_W) ? '0 : (r_a >> w_shamt);
            w_wen = 1'b1;
        end
    end

    assign w_taken   = w_is_b || (w_is_cbz && (r_b == '0)) || (w_is_blt && (r_n != r_v));
    assign w_pc_next = w_taken ? (r_pc + (w_is_b ? w_off_b : w_off_c)) : (r_pc + DATA_W'(4));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (imem_ack) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (w_is_halt)     w_next = S_HALT;
                else if (w_is_mem) w_next = S_MEM;
                else               w_next = S_FETCH;
            end
            S_MEM:    if (dmem_ack) w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_ir   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_addr <= '0;
            r_n    <= 1'b0;
            r_z    <= 1'b0;
            r_c    <= 1'b0;
            r_v    <= 1'b0;
            for (int i = 0; i < 31; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (imem_ack) r_ir <= imem_rdata;
                S_DECODE: begin
                    r_a <= w_rn_val;
                    r_b <= (w_is_stur || w_is_cbz) ? w_rt_val : w_rm_val;
                end
                S_EXEC: begin
                    if (w_is_mem) begin
                        r_addr <= w_daddr;
                    end else if (!w_is_halt) begin
                        r_pc <= w_pc_next;
                        if (w_wen && (w_rd != 5'd31)) r_regs[w_rd] <= w_res;
                        if (w_is_adds || w_is_subs) begin
                            r_n <= w_sum[DATA_W-1];
                            r_z <= (w_sum == '0);
                            r_c <= w_carry;
                            r_v <= w_ovf;
                        end
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (w_is_ldur && (w_rd != 5'd31)) r_regs[w_rd] <= dmem_rdata;
                        r_pc <= r_pc + DATA_W'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req   = (r_state == S_FETCH) && !rst;
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM) && !rst;
    assign dmem_we    = w_is_stur;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_b;
    assign pc_out     = r_pc;
    assign halted     = (r_state == S_HALT);

    always_comb begin
        for (int i = 0; i < 31; i++) reg_out[i] = r_regs[i];
        reg_out[31] = '0;
    end

endmodule
